// File: rtl/serial_addsub_if.sv
// Request/response bundle for the serial add/subtract unit.
// The requester drives operands and start; the unit returns the result and NZCV flags.
interface serial_addsub_if #(
  parameter int WIDTH = 64
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             negative;
  logic             zero;
  logic             carry_out;
  logic             overflow;

  modport master (
    output start, sub, A, B,
    input  busy, done, result,
    input  negative, zero, carry_out, overflow
  );

  modport slave (
    input  start, sub, A, B,
    output busy, done, result,
    output negative, zero, carry_out, overflow
  );
endinterface

// File: rtl/serial_addsub.sv
// Multi-cycle add/subtract built from a short chain of full-adder cells.
// It processes BITS_PER_CYCLE bits per clock, LSB first, and reports ARM-style NZCV flags.
module adder1 (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);
  assign s_o    = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));
endmodule

module serial_addsub #(
  parameter int WIDTH          = 64,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic           clk,
  input  logic           reset,
  serial_addsub_if.slave bus
);
  localparam int BPC   = BITS_PER_CYCLE;
  localparam int STEPS = WIDTH / BPC;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     opa_q, opa_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic [WIDTH-BPC-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]     res_q, res_d;
  logic                 carry_q, carry_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           nzcv_q, nzcv_d;

  logic [BPC:0]         c;
  logic [BPC-1:0]       s;
  logic [WIDTH-1:0]     full;
  logic                 last;

  assign c[0] = carry_q;

  for (genvar i = 0; i < BPC; i++) begin : g_chain
    adder1 u_fa (
      .a_i    (opa_q[i]),
      .b_i    (opb_q[i]),
      .cin_i  (c[i]),
      .s_o    (s[i]),
      .cout_o (c[i+1])
    );
  end

  // Operands shift right each step; sums enter the shadow from the top.
  assign full = {s, acc_q};
  assign last = (cnt_q == CW'(STEPS - 1));

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    nzcv_d  = nzcv_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          state_d = RUN;
          opa_d   = bus.A;
          opb_d   = bus.sub ? ~bus.B : bus.B;
          carry_d = bus.sub;
          cnt_d   = '0;
        end
      end
      RUN: begin
        opa_d   = opa_q >> BPC;
        opb_d   = opb_q >> BPC;
        acc_d   = full[WIDTH-1:BPC];
        carry_d = c[BPC];
        cnt_d   = cnt_q + 1'b1;
        if (last) begin
          state_d = DONE;
          cnt_d   = '0;
          res_d   = full;
          // Low operand bits now hold the original MSB slice.
          nzcv_d  = {s[BPC-1],
                     (full == '0),
                     c[BPC],
                     opa_q[BPC-1] ^ opb_q[BPC-1]
                       ^ s[BPC-1] ^ c[BPC]};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      nzcv_q  <= '0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      nzcv_q  <= nzcv_d;
    end
  end

  assign bus.busy      = (state_q == RUN);
  assign bus.done      = (state_q == DONE);
  assign bus.result    = res_q;
  assign bus.negative  = nzcv_q[3];
  assign bus.zero      = nzcv_q[2];
  assign bus.carry_out = nzcv_q[1];
  assign bus.overflow  = nzcv_q[0];
endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: one unit at 1 bit/cycle and one at 4 bits/cycle,
// driven in parallel and checked against a 65-bit arithmetic model.
module tb_serial_addsub;
  localparam int W = 64;

  logic clk = 1'b0;
  logic rst1, rst4;
  always #5 clk = ~clk;

  serial_addsub_if #(.WIDTH(W)) if1 ();
  serial_addsub_if #(.WIDTH(W)) if4 ();

  serial_addsub #(.WIDTH(W), .BITS_PER_CYCLE(1)) u_d1 (
    .clk   (clk),
    .reset (rst1),
    .bus   (if1.slave)
  );

  serial_addsub #(.WIDTH(W), .BITS_PER_CYCLE(4)) u_d4 (
    .clk   (clk),
    .reset (rst4),
    .bus   (if4.slave)
  );

  typedef struct {
    logic [W-1:0] r;
    logic [3:0]   f;
  } exp_t;

  exp_t         q1[$];
  exp_t         q4[$];
  logic [W-1:0] last[2];
  int           total = 0;
  int           bad   = 0;

  function automatic exp_t model(input logic [W-1:0] a,
                                 input logic [W-1:0] b,
                                 input logic s);
    logic [W:0]   sum;
    logic [W-1:0] bb;
    exp_t         e;
    bb   = s ? ~b : b;
    sum  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, s};
    e.r  = sum[W-1:0];
    e.f  = {e.r[W-1], (e.r == '0), sum[W],
            (a[W-1] == bb[W-1]) && (e.r[W-1] != a[W-1])};
    return e;
  endfunction

  task automatic issue(input int d, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic s);
    if (d == 0) begin
      if1.start = 1'b1; if1.A = a; if1.B = b; if1.sub = s;
      q1.push_back(model(a, b, s));
    end else begin
      if4.start = 1'b1; if4.A = a; if4.B = b; if4.sub = s;
      q4.push_back(model(a, b, s));
    end
  endtask

  task automatic run_op(input string nm,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input int inj, input bit b2b,
                        input logic [W-1:0] a2, input logic [W-1:0] b2,
                        input logic s2);
    int           cyc[2], bsy[2], left[2], lat[2];
    exp_t         e;
    logic         dn, bz;
    logic [W-1:0] r;
    logic [3:0]   f;
    lat[0] = W + 1;
    lat[1] = W / 4 + 1;
    for (int d = 0; d < 2; d++) begin
      issue(d, a, b, s);
      cyc[d] = 0; bsy[d] = 0; left[d] = b2b ? 2 : 1;
    end
    for (int t = 0; t < 400 && (left[0] > 0 || left[1] > 0); t++) begin
      @(posedge clk); #1;
      if1.start = 1'b0;
      if4.start = 1'b0;
      for (int d = 0; d < 2; d++) begin
        if (left[d] > 0) begin
          cyc[d]++;
          bz = d ? if4.busy : if1.busy;
          dn = d ? if4.done : if1.done;
          r  = d ? if4.result : if1.result;
          f  = d ? {if4.negative, if4.zero, if4.carry_out, if4.overflow}
                 : {if1.negative, if1.zero, if1.carry_out, if1.overflow};
          if (bz) bsy[d]++;
          if (cyc[d] == inj) begin
            total++;
            if (r !== last[d]) begin
              bad++;
              $display("FAIL %s shadow d%0d: got %h want %h", nm, d, r, last[d]);
            end
          end
          if (dn) begin
            total++;
            if ((d ? q4.size() : q1.size()) == 0) begin
              bad++;
              $display("FAIL %s spurious done d%0d", nm, d);
            end else begin
              e = d ? q4.pop_front() : q1.pop_front();
              last[d] = e.r;
              if (r !== e.r) begin
                bad++;
                $display("FAIL %s result d%0d: got %h want %h", nm, d, r, e.r);
              end
              total++;
              if (f !== e.f) begin
                bad++;
                $display("FAIL %s nzcv d%0d: got %b want %b", nm, d, f, e.f);
              end
              total++;
              if (cyc[d] != lat[d]) begin
                bad++;
                $display("FAIL %s latency d%0d: got %0d want %0d", nm, d, cyc[d], lat[d]);
              end
              total++;
              if (bsy[d] != lat[d] - 1) begin
                bad++;
                $display("FAIL %s busy d%0d: got %0d want %0d", nm, d, bsy[d], lat[d] - 1);
              end
            end
            left[d]--;
            if (left[d] > 0) begin
              issue(d, a2, b2, s2);
              cyc[d] = 0; bsy[d] = 0;
            end
          end
        end
      end
      if (cyc[0] == inj) begin
        if1.start = 1'b1; if1.A = 1; if1.B = 0; if1.sub = 1'b0;
        if4.start = 1'b1; if4.A = 1; if4.B = 0; if4.sub = 1'b0;
      end
    end
    for (int d = 0; d < 2; d++) begin
      total++;
      if (left[d] != 0) begin
        bad++;
        $display("FAIL %s timeout d%0d: got %0d pending want 0", nm, d, left[d]);
      end
    end
    if1.start = 1'b0;
    if4.start = 1'b0;
  endtask

  task automatic test_reset;
    rst1 = 1'b1; rst4 = 1'b1;
    if1.start = 1'b0; if1.sub = 1'b0; if1.A = '0; if1.B = '0;
    if4.start = 1'b0; if4.sub = 1'b0; if4.A = '0; if4.B = '0;
    repeat (3) @(posedge clk);
    #1;
    rst1 = 1'b0; rst4 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    last[0] = '0; last[1] = '0;
    for (int d = 0; d < 2; d++) begin
      logic [W+2:0] o;
      o = d ? {if4.busy, if4.done, if4.result, if4.negative}
            : {if1.busy, if1.done, if1.result, if1.negative};
      total++;
      if (o !== '0) begin
        bad++;
        $display("FAIL reset bus d%0d: got %h want 0", d, o);
      end
      total++;
      if ((d ? {if4.zero, if4.carry_out, if4.overflow}
             : {if1.zero, if1.carry_out, if1.overflow}) !== 3'b000) begin
        bad++;
        $display("FAIL reset zcv d%0d: got nonzero want 000", d);
      end
    end
  endtask

  task automatic test_add;
    run_op("add", 64'd5, 64'd3, 1'b0, -1, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic test_sub_neg;
    run_op("subneg", 64'd3, 64'd5, 1'b1, -1, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic test_overflow;
    run_op("ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, -1, 1'b0,
           '0, '0, 1'b0);
    run_op("ones", '1, '1, 1'b0, -1, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic test_ignore_busy;
    run_op("zero_ign", 64'd7, 64'd7, 1'b1, 10, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic test_back_to_back;
    run_op("b2b", 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
           1'b0, -1, 1'b1,
           64'h8000_0000_0000_0000, 64'd1, 1'b1);
  endtask

  task automatic test_random;
    for (int i = 0; i < 4; i++) begin
      run_op("rand", {$urandom, $urandom}, {$urandom, $urandom},
             1'($urandom_range(1)), -1, 1'b0, '0, '0, 1'b0);
    end
  endtask

  task automatic test_abort;
    int dones;
    dones = 0;
    if1.start = 1'b1; if1.A = 64'd9; if1.B = 64'd4; if1.sub = 1'b0;
    if4.start = 1'b1; if4.A = 64'd9; if4.B = 64'd4; if4.sub = 1'b0;
    for (int t = 1; t <= 100; t++) begin
      @(posedge clk); #1;
      if1.start = 1'b0;
      if4.start = 1'b0;
      if (if1.done || if4.done) dones++;
      if (t == 9)  begin rst4 = 1'b1; if4.start = 1'b1; end
      if (t == 19) begin rst1 = 1'b1; if1.start = 1'b1; end
      if (t == 10) begin
        total++;
        if ({if4.busy, if4.done, if4.result, if4.zero, if4.carry_out} !== '0) begin
          bad++;
          $display("FAIL abort4: busy=%b done=%b res=%h want 0", if4.busy, if4.done, if4.result);
        end
        rst4 = 1'b0;
      end
      if (t == 20) begin
        total++;
        if ({if1.busy, if1.done, if1.result, if1.zero, if1.carry_out} !== '0) begin
          bad++;
          $display("FAIL abort1: busy=%b done=%b res=%h want 0", if1.busy, if1.done, if1.result);
        end
        rst1 = 1'b0;
      end
    end
    total++;
    if (dones != 0) begin
      bad++;
      $display("FAIL abort done: got %0d pulses want 0", dones);
    end
    last[0] = '0; last[1] = '0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_neg();
    test_overflow();
    test_ignore_busy();
    test_back_to_back();
    test_random();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
